// File: rtl/mem_initiator_if.sv
// Host command/response channels and memory bus of the mem_initiator.
// master = initiator side, slave = host plus memory side.
interface mem_initiator_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [7:0]    cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_perr;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW:0]   mem_data_out;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
        input  rsp_ready, mem_data_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_perr,
        output mem_write, mem_read, mem_address, mem_data_in
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
        output rsp_ready, mem_data_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_perr,
        input  mem_write, mem_read, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_initiator.sv
// Bus master for the parity-protected memory: single writes, burst reads,
// fixed read latency, even-parity check on each returned beat.
module mem_initiator #(
    parameter int RD_LAT = 8,
    parameter int AW     = 16,
    parameter int DW     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_initiator_if.master     bus,
    output logic                busy,
    output logic [15:0]         perr_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_WAIT, S_RESP
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    beats_q;
    logic [7:0]    cnt_q;
    logic [15:0]   perr_cnt_q;
    logic          accept, capture, ld_addr, perr;
    logic          mem_write_d, mem_read_d, cmd_ready_d;

    assign accept  = (state_q == S_IDLE) & bus.cmd_valid;
    assign capture = (state_q == S_WAIT) & (cnt_q == 8'd0);
    assign perr    = ^bus.mem_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept)
                        state_d = bus.cmd_write ? S_WR : S_RD;
            S_WR:   state_d = S_IDLE;
            S_RD:   state_d = S_WAIT;
            S_WAIT: if (capture) state_d = S_RESP;
            S_RESP: if (bus.rsp_ready)
                        state_d = (beats_q > 8'd1) ? S_RD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and ready are decoded from the next state so they are
    // registered yet line up with the state they belong to.
    always_comb begin
        mem_write_d = (state_d == S_WR);
        mem_read_d  = (state_d == S_RD);
        cmd_ready_d = (state_d == S_IDLE);
        ld_addr     = accept |
                      ((state_q == S_RESP) & (state_d == S_RD));
        addr_d      = accept ? bus.cmd_addr : addr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd_ready   <= 1'b1;
            bus.mem_write   <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_addr    <= '0;
            bus.rsp_perr    <= 1'b0;
            addr_q          <= '0;
            beats_q         <= '0;
            cnt_q           <= '0;
            perr_cnt_q      <= '0;
        end else begin
            bus.cmd_ready <= cmd_ready_d;
            bus.mem_write <= mem_write_d;
            bus.mem_read  <= mem_read_d;
            if (ld_addr) begin
                addr_q          <= addr_d;
                bus.mem_address <= addr_d;
            end
            if (accept) begin
                beats_q <= (bus.cmd_len == 8'd0) ? 8'd1 : bus.cmd_len;
                if (bus.cmd_write) bus.mem_data_in <= bus.cmd_wdata;
            end
            if (state_q == S_RD)
                cnt_q <= LAT_M1;
            else if ((state_q == S_WAIT) && (cnt_q != 8'd0))
                cnt_q <= cnt_q - 8'd1;
            if (capture) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= bus.mem_data_out[DW-1:0];
                bus.rsp_addr  <= addr_q;
                bus.rsp_perr  <= perr;
                if (perr && (perr_cnt_q != 16'hFFFF))
                    perr_cnt_q <= perr_cnt_q + 16'd1;
            end
            if ((state_q == S_RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                beats_q       <= beats_q - 8'd1;
            end
        end
    end

    assign busy       = ~bus.cmd_ready;
    assign perr_count = perr_cnt_q;
endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural parity memory.
// Inputs driven on negedge; outputs sampled on negedge.
module tb_mem_initiator;
    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] perr_count;

    always #5 clk = ~clk;

    mem_initiator_if #(.AW(16), .DW(8)) bus ();

    mem_initiator #(.RD_LAT(LAT), .AW(16), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .busy       (busy),
        .perr_count (perr_count)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        p;
    } beat_t;

    beat_t       rsp_q[$];
    logic [15:0] rd_q[$];
    logic [8:0]  mem [logic [15:0]];
    int          n_vec = 0;
    int          n_miss = 0;
    int          overlap = 0;
    logic        bad_en = 1'b0;
    logic [15:0] bad_addr = '0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] word(logic [7:0] d);
        return {^d, d};
    endfunction

    // memory model and observers
    always begin
        @(negedge clk);
        #1;
        if (bus.mem_write & bus.mem_read) overlap++;
        if (bus.mem_write)
            mem[bus.mem_address] = word(bus.mem_data_in);
        if (bus.mem_read) begin
            rd_q.push_back(bus.mem_address);
            bus.mem_data_out =
                (mem.exists(bus.mem_address) ? mem[bus.mem_address] : 9'h0) ^
                ((bad_en && bus.mem_address == bad_addr) ? 9'h100 : 9'h0);
        end
        if (bus.rsp_valid & bus.rsp_ready)
            rsp_q.push_back(beat_t'{a: bus.rsp_addr, d: bus.rsp_data,
                                    p: bus.rsp_perr});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic send(logic w, logic [15:0] a, logic [7:0] d,
                        logic [7:0] len);
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 60 && !bus.cmd_ready; i++) @(negedge clk);
        check("accept_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && !bus.cmd_ready; i++) @(negedge clk);
        check("idle", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic clear();
        rsp_q.delete();
        rd_q.delete();
    endtask

    initial begin
        logic [15:0] ea[4];
        logic [7:0]  ed[4];
        logic [7:0]  sd;
        logic [15:0] sa;
        int          lat, hold_bad, rds;

        rst_n            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_write    = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_wdata    = '0;
        bus.cmd_len      = '0;
        bus.rsp_ready    = 1'b1;
        bus.mem_data_out = '0;
        #12;
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_outs", {bus.mem_write, bus.mem_read, bus.rsp_valid,
                           busy, perr_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single write
        send(1'b1, 16'h0100, 8'hA5, 8'd0);
        check("wr_strobe", {bus.mem_write, bus.mem_read}, 32'b10);
        check("wr_data", bus.mem_data_in, 32'hA5);
        check("wr_addr", bus.mem_address, 32'h0100);
        @(negedge clk);
        check("wr_one_cycle", 32'(bus.mem_write), 32'd0);
        check("wr_ready_back", 32'(bus.cmd_ready), 32'd1);

        // single read, latency
        clear();
        send(1'b0, 16'h0100, 8'h00, 8'd1);
        check("rd_strobe", {bus.mem_write, bus.mem_read}, 32'b01);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = i - 1;
                break;
            end
        end
        check("rd_latency", lat, LAT);
        check("rd_data", bus.rsp_data, 32'hA5);
        check("rd_perr", 32'(bus.rsp_perr), 32'd0);
        wait_idle();
        check("rd_beats", rsp_q.size(), 1);

        // wrapping burst
        ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        ed = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) mem[ea[i]] = word(ed[i]);
        clear();
        send(1'b0, 16'hFFFE, 8'h00, 8'd4);
        wait_idle();
        check("burst_reads", rd_q.size(), 4);
        check("burst_beats", rsp_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check($sformatf("burst_maddr%0d", i), rd_q[i], ea[i]);
        for (int i = 0; i < 4 && i < rsp_q.size(); i++)
            check($sformatf("burst_rsp%0d", i),
                  {rsp_q[i].a, rsp_q[i].d, rsp_q[i].p},
                  {ea[i], ed[i], 1'b0});

        // parity error on the middle beat
        mem[16'h0010] = word(8'h3C);
        mem[16'h0011] = word(8'h7E);
        mem[16'h0012] = word(8'h81);
        bad_en   = 1'b1;
        bad_addr = 16'h0011;
        clear();
        send(1'b0, 16'h0010, 8'h00, 8'd3);
        wait_idle();
        check("perr_beats", rsp_q.size(), 3);
        if (rsp_q.size() == 3) begin
            check("perr_flags", {rsp_q[0].p, rsp_q[1].p, rsp_q[2].p},
                  32'b010);
            check("perr_data", rsp_q[1].d, 32'h7E);
        end
        check("perr_count1", perr_count, 32'd1);

        // saturation
        force dut.perr_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.perr_cnt_q;
        @(negedge clk);
        send(1'b0, 16'h0011, 8'h00, 8'd1);
        wait_idle();
        check("perr_to_max", perr_count, 32'hFFFF);
        send(1'b0, 16'h0011, 8'h00, 8'd1);
        wait_idle();
        check("perr_saturate", perr_count, 32'hFFFF);
        bad_en = 1'b0;

        // response stall
        mem[16'h0101] = word(8'h5A);
        bus.rsp_ready = 1'b0;
        clear();
        send(1'b0, 16'h0100, 8'h00, 8'd2);
        for (int i = 0; i < 40 && !bus.rsp_valid; i++) @(negedge clk);
        check("stall_valid", 32'(bus.rsp_valid), 32'd1);
        sd = bus.rsp_data;
        sa = bus.rsp_addr;
        hold_bad = 0;
        rds = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_data != sd || bus.rsp_addr != sa ||
                !bus.rsp_valid || bus.cmd_ready)
                hold_bad++;
            if (bus.mem_read) rds++;
        end
        check("stall_hold", hold_bad, 0);
        check("stall_no_rd", rds, 0);
        check("stall_beat0", {sa, sd}, {16'h0100, 8'hA5});
        check("stall_rd_q", rd_q.size(), 1);
        bus.rsp_ready = 1'b1;
        wait_idle();
        check("stall_beats", rsp_q.size(), 2);
        if (rsp_q.size() == 2)
            check("stall_beat1", {rsp_q[1].a, rsp_q[1].d},
                  {16'h0101, 8'h5A});

        // reset in WAIT of a 3-beat burst
        clear();
        send(1'b0, 16'h0010, 8'h00, 8'd3);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outs", {bus.mem_write, bus.mem_read, bus.rsp_valid,
                            busy, perr_count}, 32'd0);
        check("arst_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear();
        send(1'b0, 16'h0100, 8'h00, 8'd0);
        wait_idle();
        check("len0_reads", rd_q.size(), 1);
        check("len0_beats", rsp_q.size(), 1);
        if (rsp_q.size() == 1)
            check("len0_rsp", {rsp_q[0].a, rsp_q[0].d, rsp_q[0].p},
                  {16'h0100, 8'hA5, 1'b0});
        check("strobe_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end
endmodule
